// File: rtl/irq_ctrl_if.sv
// CPU-facing bus of the interrupt controller: config register port plus the
// request/ack/eoi handshake and the vector written into sR1.
interface irq_ctrl_if #(
  parameter int IDW = 3,
  parameter int DW  = 16
);
  logic           cfg_we;
  logic [1:0]     cfg_addr;
  logic [DW-1:0]  cfg_wdata;
  logic [DW-1:0]  cfg_rdata;
  logic           intr;
  logic [IDW-1:0] irq_nr;
  logic [DW-1:0]  sr1_wr;
  logic           ack;
  logic           eoi;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, ack, eoi,
    input  cfg_rdata, intr, irq_nr, sr1_wr
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, ack, eoi,
    output cfg_rdata, intr, irq_nr, sr1_wr
  );
endinterface

// File: rtl/irq_ctrl.sv
// N-channel prioritised interrupt controller: per-channel synchroniser, mode,
// enable and pending latch, feeding a single request with ack/eoi handshake.
module irq_lane (
  input  logic clk,
  input  logic reset,
  input  logic irq_raw,
  input  logic we_en,
  input  logic we_mode,
  input  logic we_pend,
  input  logic wbit,
  input  logic ack_clr,
  output logic en,
  output logic mode,
  output logic pend
);
  logic sync1, sync2, prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      en    <= 1'b0;
      mode  <= 1'b0;
      pend  <= 1'b0;
    end else begin
      sync1 <= irq_raw;
      sync2 <= sync1;
      prev  <= sync2;
      if (we_en)   en   <= wbit;
      if (we_mode) mode <= wbit;
      // edge set is OR'd last so it beats a coincident W1C or ack clear
      if (!mode) pend <= sync2;
      else       pend <= (sync2 & ~prev) | (pend & ~((we_pend & wbit) | ack_clr));
    end
  end
endmodule

module irq_ctrl #(
  parameter int NIRQ = 8,
  parameter int IDW  = 3,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  irq_ctrl_if.slave       bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  nr_q, nr_nx, sel_nr;
  logic [NIRQ-1:0] en, mode, pend, elig, ack_clr;
  logic            cur_elig, take;
  logic            we_en, we_mode, we_pend;
  logic [DW-1:0]   status;
  logic            unused_wdata;

  assign we_en   = bus.cfg_we && (bus.cfg_addr == 2'd0);
  assign we_mode = bus.cfg_we && (bus.cfg_addr == 2'd1);
  assign we_pend = bus.cfg_we && (bus.cfg_addr == 2'd2);
  assign unused_wdata = ^bus.cfg_wdata;

  for (genvar i = 0; i < NIRQ; i++) begin : g_lane
    assign ack_clr[i] = take && (nr_q == IDW'(i));
    irq_lane u_lane (
      .clk     (clk),
      .reset   (reset),
      .irq_raw (irq_in[i]),
      .we_en   (we_en),
      .we_mode (we_mode),
      .we_pend (we_pend),
      .wbit    (bus.cfg_wdata[i]),
      .ack_clr (ack_clr[i]),
      .en      (en[i]),
      .mode    (mode[i]),
      .pend    (pend[i])
    );
  end

  assign elig     = pend & en;
  assign cur_elig = |(elig & (NIRQ'(1) << nr_q));

  // descending scan so the lowest eligible index is the last one written
  always_comb begin
    sel_nr = '0;
    for (int i = NIRQ - 1; i >= 0; i--)
      if (elig[i]) sel_nr = IDW'(i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      nr_q  <= '0;
    end else begin
      state <= state_nx;
      nr_q  <= nr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    nr_nx    = nr_q;
    take     = 1'b0;
    case (state)
      IDLE:
        if (|elig) begin
          state_nx = REQ;
          nr_nx    = sel_nr;
        end
      REQ:
        if (bus.ack) begin
          state_nx = SERVICE;
          take     = 1'b1;
        end else if (!cur_elig) begin
          state_nx = IDLE;
        end
      SERVICE:
        if (bus.eoi) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.intr   = (state == REQ);
  assign bus.irq_nr = nr_q;
  assign bus.sr1_wr = bus.intr ? DW'(nr_q) : '0;

  always_comb begin
    status          = '0;
    status[0]       = (state == REQ);
    status[1]       = (state == SERVICE);
    status[2 +: IDW] = nr_q;
  end

  always_comb begin
    case (bus.cfg_addr)
      2'd0:    bus.cfg_rdata = DW'(en);
      2'd1:    bus.cfg_rdata = DW'(mode);
      2'd2:    bus.cfg_rdata = DW'(pend);
      default: bus.cfg_rdata = status;
    endcase
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus queues expected values, a negedge
// monitor compares them and checks every request entry against expected irq_nr.
module tb_irq_ctrl;
  localparam int NIRQ = 8;
  localparam int IDW  = 3;
  localparam int DW   = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NIRQ-1:0] irq_in = '0;

  irq_ctrl_if #(.IDW(IDW), .DW(DW)) bus ();

  irq_ctrl #(.NIRQ(NIRQ), .IDW(IDW), .DW(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } chk_t;

  chk_t           q[$];
  logic [IDW-1:0] nr_q[$];
  int             n_chk = 0;
  int             n_fail = 0;
  logic           intr_d = 1'b0;

  // sel: 0 intr, 1 irq_nr, 2 sr1_wr, 3 cfg_rdata
  always @(negedge clk) begin
    chk_t           e;
    logic [15:0]    act;
    logic [IDW-1:0] x;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        0:       act = {15'b0, bus.intr};
        1:       act = 16'(bus.irq_nr);
        2:       act = bus.sr1_wr;
        default: act = bus.cfg_rdata;
      endcase
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
    if (bus.intr && !intr_d) begin
      n_chk++;
      if (nr_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_req: got irq_nr %0d expected no request", bus.irq_nr);
      end else begin
        x = nr_q.pop_front();
        if (bus.irq_nr !== x || bus.sr1_wr !== 16'(x)) begin
          n_fail++;
          $display("FAIL req_vector: got irq_nr %0d sr1_wr %h expected %0d / %h",
                   bus.irq_nr, bus.sr1_wr, x, 16'(x));
        end
      end
    end
    intr_d <= bus.intr;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(string nm, int sel, logic [15:0] exp);
    chk_t e;
    e.name = nm;
    e.sel  = sel;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic rd(string nm, logic [1:0] a, logic [15:0] exp);
    bus.cfg_addr = a;
    chk(nm, 3, exp);
  endtask

  task automatic cfg_wr(logic [1:0] a, logic [15:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    tick(1);
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1;
    tick(1);
    bus.ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.eoi = 1'b1;
    tick(1);
    bus.eoi = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wdata = '0;
    bus.ack = 1'b0; bus.eoi = 1'b0;

    // reset: writes and a source pulse during reset leave everything cleared
    bus.cfg_we = 1'b1; bus.cfg_wdata = 16'h00FF; irq_in[5] = 1'b1;
    tick(2);
    irq_in[5] = 1'b0; bus.cfg_we = 1'b0;
    chk("rst_intr", 0, 16'h0); chk("rst_nr", 1, 16'h0); chk("rst_sr1", 2, 16'h0);
    rd("rst_enable", 2'd0, 16'h0); sample();
    reset = 1'b0;
    tick(1);
    rd("rst_mode", 2'd1, 16'h0); sample();
    rd("rst_pend", 2'd2, 16'h0); sample();
    rd("rst_status", 2'd3, 16'h0); sample();

    // level latency on channel 5
    cfg_wr(2'd0, 16'h00FF);
    rd("enable_ff", 2'd0, 16'h00FF); sample();
    irq_in[5] = 1'b1; nr_q.push_back(3'd5);
    tick(3);
    chk("lat_intr_e3", 0, 16'h0); rd("lat_pend_e3", 2'd2, 16'h0020); sample();
    tick(1);
    chk("lat_intr_e4", 0, 16'h1); chk("lat_nr", 1, 16'h5); chk("lat_sr1", 2, 16'h0005); sample();
    pulse_ack();
    chk("ack_intr", 0, 16'h0); chk("ack_sr1", 2, 16'h0); rd("ack_status", 2'd3, 16'h0016); sample();
    irq_in[5] = 1'b0;
    tick(3);
    pulse_eoi();
    rd("eoi_status", 2'd3, 16'h0014); sample();
    tick(2);
    chk("eoi_no_rereq", 0, 16'h0); sample();

    // priority and freeze
    irq_in[6] = 1'b1; irq_in[3] = 1'b1; nr_q.push_back(3'd3);
    tick(3);
    rd("prio_pend", 2'd2, 16'h0048); sample();
    tick(1);
    chk("prio_intr", 0, 16'h1); chk("prio_nr", 1, 16'h3); sample();
    irq_in[1] = 1'b1;
    tick(4);
    chk("freeze_nr", 1, 16'h3); chk("freeze_intr", 0, 16'h1); rd("freeze_pend", 2'd2, 16'h004A); sample();
    pulse_ack();
    rd("prio_status", 2'd3, 16'h000E); sample();
    irq_in[3] = 1'b0;
    tick(3);
    nr_q.push_back(3'd1);
    pulse_eoi();
    tick(1);
    chk("next_intr", 0, 16'h1); chk("next_nr", 1, 16'h1); chk("next_sr1", 2, 16'h0001); sample();
    pulse_ack();
    irq_in = '0;
    tick(3);
    pulse_eoi();
    tick(2);
    chk("prio_done_intr", 0, 16'h0); rd("prio_done_pend", 2'd2, 16'h0); sample();

    // edge mode on channel 2
    cfg_wr(2'd1, 16'h0004);
    irq_in[2] = 1'b1; nr_q.push_back(3'd2);
    tick(3);
    irq_in[2] = 1'b0;
    rd("edge_pend", 2'd2, 16'h0004); chk("edge_intr_e3", 0, 16'h0); sample();
    tick(1);
    chk("edge_intr", 0, 16'h1); rd("edge_pend_req", 2'd2, 16'h0004); sample();
    pulse_ack();
    chk("edge_ack_intr", 0, 16'h0); rd("edge_ack_pend", 2'd2, 16'h0000); sample();
    pulse_eoi();
    tick(2);
    chk("edge_no_rereq", 0, 16'h0); sample();
    cfg_wr(2'd0, 16'h00FB);
    irq_in[2] = 1'b1;
    tick(2);
    cfg_wr(2'd2, 16'h0004);
    rd("set_beats_w1c", 2'd2, 16'h0004); sample();
    cfg_wr(2'd2, 16'h0004);
    rd("w1c_clears", 2'd2, 16'h0000); chk("w1c_intr", 0, 16'h0); sample();
    irq_in[2] = 1'b0;
    tick(3);
    cfg_wr(2'd1, 16'h0000);
    tick(2);
    cfg_wr(2'd0, 16'h00FF);

    // withdrawal by disabling channel 4 in REQ
    irq_in[4] = 1'b1; nr_q.push_back(3'd4);
    tick(4);
    chk("wd_intr", 0, 16'h1); chk("wd_nr", 1, 16'h4); sample();
    cfg_wr(2'd0, 16'h00EF);
    chk("wd_intr_hold", 0, 16'h1); sample();
    tick(1);
    chk("wd_intr_fall", 0, 16'h0); rd("wd_status", 2'd3, 16'h0010); sample();
    pulse_ack();
    rd("late_ack_status", 2'd3, 16'h0010); sample();
    irq_in[4] = 1'b0;
    tick(3);
    cfg_wr(2'd0, 16'h00FF);

    // handshake misuse
    pulse_eoi();
    rd("eoi_idle", 2'd3, 16'h0010); sample();
    irq_in[0] = 1'b1; nr_q.push_back(3'd0);
    tick(4);
    rd("ch0_req", 2'd3, 16'h0001); sample();
    pulse_eoi();
    rd("eoi_req", 2'd3, 16'h0001); sample();
    pulse_ack();
    rd("ch0_svc", 2'd3, 16'h0002); sample();
    pulse_ack();
    rd("ack_svc", 2'd3, 16'h0002); sample();
    irq_in[0] = 1'b0;
    tick(3);
    pulse_eoi();
    tick(2);
    chk("misuse_idle", 0, 16'h0); sample();
    irq_in[7] = 1'b1; nr_q.push_back(3'd7);
    tick(4);
    chk("ch7_intr", 0, 16'h1); chk("ch7_nr", 1, 16'h7); sample();
    cfg_wr(2'd0, 16'h007F);
    pulse_ack();
    rd("ack_wins", 2'd3, 16'h001E); chk("ack_wins_intr", 0, 16'h0); sample();

    // async reset mid-SERVICE drops pending edges
    cfg_wr(2'd1, 16'h0001);
    irq_in[0] = 1'b1;
    tick(3);
    rd("svc_pend", 2'd2, 16'h0081); sample();
    tick(1);
    reset = 1'b1; irq_in = '0;
    rd("arst_status", 2'd3, 16'h0); chk("arst_intr", 0, 16'h0); sample();
    rd("arst_pend", 2'd2, 16'h0); sample();
    tick(1);
    reset = 1'b0;
    tick(6);
    chk("post_rst_intr", 0, 16'h0); rd("post_rst_pend", 2'd2, 16'h0); sample();
    rd("post_rst_enable", 2'd0, 16'h0); sample();

    n_chk++;
    if (nr_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_req: got %0d requests outstanding expected 0", nr_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
